// File: rtl/div_pkg.sv
// Shared types and defaults for the repeated-subtraction divider.
package div_pkg;

   // Default divisor/remainder width; dividend and quotient are twice this.
   localparam int DIV_W = 4;

   // Controller states, in the order a normal division visits them.
   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      SUB,
      DONE
   } div_state_t;

endpackage

// File: rtl/divider_if.sv
// Handshake and operand/result bundle between a requester and the divider.
interface divider_if import div_pkg::*; #(
   parameter int W = DIV_W
);
   logic             start_i;
   logic [2*W-1:0]   in_data;
   logic [2*W-1:0]   quotient_o;
   logic [W-1:0]     remainder_o;
   logic             done_o;
   logic             busy_o;
   logic             div_zero_o;

   // Requester side: drives start and the time-multiplexed operand bus.
   modport master (
      output start_i, in_data,
      input  quotient_o, remainder_o, done_o, busy_o, div_zero_o
   );

   // Divider side.
   modport slave (
      input  start_i, in_data,
      output quotient_o, remainder_o, done_o, busy_o, div_zero_o
   );
endinterface

// File: rtl/div_datapath.sv
// Divider datapath: running remainder R, divisor D, quotient Q,
// a 2W-bit compare/subtract against zero-extended D, and a zero-divisor flag.
module div_datapath import div_pkg::*; #(
   parameter int W = DIV_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load_r,
   input  logic           load_d,
   input  logic           clr_q,
   input  logic           sub_en,
   input  logic           set_dz,
   input  logic [2*W-1:0] in_data,
   output logic           ge_o,
   output logic           dz_o,
   output logic [2*W-1:0] q_o,
   output logic [W-1:0]   r_low_o,
   output logic           div_zero_o
);
   localparam logic [2*W-1:0] ONE = {{(2*W-1){1'b0}}, 1'b1};

   logic [2*W-1:0] r_reg;
   logic [2*W-1:0] q_reg;
   logic [W-1:0]   d_reg;
   logic           dz_reg;
   logic [2*W-1:0] d_ext;

   // Compare and subtract happen at full dividend width, so R never wraps.
   assign d_ext      = {{W{1'b0}}, d_reg};
   assign ge_o       = (r_reg >= d_ext);
   // Checked on the bus itself so the controller can branch in LOAD_B.
   assign dz_o       = (in_data[W-1:0] == '0);
   assign q_o        = q_reg;
   assign r_low_o    = r_reg[W-1:0];
   assign div_zero_o = dz_reg;

   // R/D/Q/flag updates, each driven by one controller strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_reg  <= '0;
         d_reg  <= '0;
         q_reg  <= '0;
         dz_reg <= 1'b0;
      end else begin
         if (load_r)
            r_reg <= in_data;
         else if (sub_en)
            r_reg <= r_reg - d_ext;

         if (load_d)
            d_reg <= in_data[W-1:0];

         if (clr_q) begin
            q_reg  <= '0;
            dz_reg <= 1'b0;
         end else if (set_dz) begin
            q_reg  <= '1;
            dz_reg <= 1'b1;
         end else if (sub_en) begin
            q_reg  <= q_reg + ONE;
         end
      end
   end

endmodule

// File: rtl/divider.sv
// Sequential unsigned divider (2W-bit dividend / W-bit divisor) by repeated
// subtraction, with a start/done handshake and a shared operand bus.
module divider import div_pkg::*; #(
   parameter int W = DIV_W
) (
   input  logic      clk_in,
   input  logic      rst_in,
   divider_if.slave  bus
);
   div_state_t     state;
   logic           done_reg;
   logic           busy_reg;
   logic [W-1:0]   rem_reg;

   logic           load_r;
   logic           load_d;
   logic           clr_q;
   logic           sub_en;
   logic           set_dz;
   logic           ge;
   logic           dz;
   logic [2*W-1:0] q;
   logic [W-1:0]   r_low;
   logic           div_zero;

   div_datapath #(.W(W)) u_datapath (
      .clk        (clk_in),
      .rst_n      (rst_in),
      .load_r     (load_r),
      .load_d     (load_d),
      .clr_q      (clr_q),
      .sub_en     (sub_en),
      .set_dz     (set_dz),
      .in_data    (bus.in_data),
      .ge_o       (ge),
      .dz_o       (dz),
      .q_o        (q),
      .r_low_o    (r_low),
      .div_zero_o (div_zero)
   );

   // Datapath strobes decoded from the current state and datapath status.
   always_comb begin
      load_r = 1'b0;
      clr_q  = 1'b0;
      load_d = 1'b0;
      set_dz = 1'b0;
      sub_en = 1'b0;
      case (state)
         LOAD_A: begin
            load_r = 1'b1;
            clr_q  = 1'b1;
         end
         LOAD_B: begin
            load_d = 1'b1;
            set_dz = dz;
         end
         SUB:     sub_en = ge;
         default: ;
      endcase
   end

   // Controller: state sequencing plus registered done/busy/remainder outputs.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state    <= IDLE;
         done_reg <= 1'b0;
         busy_reg <= 1'b0;
         rem_reg  <= '0;
      end else begin
         done_reg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start_i) begin
                  state    <= LOAD_A;
                  busy_reg <= 1'b1;
               end
            end
            LOAD_A: begin
               rem_reg <= '0;
               state   <= LOAD_B;
            end
            LOAD_B: begin
               if (dz) begin
                  rem_reg  <= '0;
                  done_reg <= 1'b1;
                  state    <= DONE;
               end else begin
                  state    <= SUB;
               end
            end
            SUB: begin
               // Once R drops below D it already fits in W bits.
               if (!ge) begin
                  rem_reg  <= r_low;
                  done_reg <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               busy_reg <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy_reg <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   assign bus.quotient_o  = q;
   assign bus.remainder_o = rem_reg;
   assign bus.done_o      = done_reg;
   assign bus.busy_o      = busy_reg;
   assign bus.div_zero_o  = div_zero;

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential unsigned divider using repeated subtraction; it is the inverse companion to the team's repeated-addition multiplier.
- Uses the same start/done handshake and the same time-multiplexed operand bus on in_data.
- Dividend is 2W bits and divisor is W bits, so any multiplier product can be divided back by either of its factors.

Parameters:
- W, default 4: divisor and remainder width. Dividend and quotient are 2W bits wide.

Ports:
- clk_in  input  1  Clock; all state updates on the rising edge.
- rst_in  input  1  Asynchronous, active-low reset.
- start_i  input  1  Start request; sampled only in IDLE.
- in_data  input  2W  Operand bus: dividend in LOAD_A; divisor in LOAD_B, low W bits used and upper bits ignored.
- quotient_o  output  2W  Quotient register.
- remainder_o  output  W  Remainder register.
- done_o  output  1  One-cycle pulse when the result is valid.
- busy_o  output  1  High in every state except IDLE.
- div_zero_o  output  1  Set when the divisor was 0; held with the result.

Behaviour:
- Reset (rst_in low, at any time, including mid-operation):
  - state goes to IDLE.
  - quotient_o, remainder_o, done_o, busy_o and div_zero_o all go to 0.
  - The internal R and D registers go to 0.
- States and transitions:
  - IDLE: if start_i=1, go to LOAD_A; otherwise stay.
  - LOAD_A: R <= in_data; Q <= 0; div_zero <= 0; go to LOAD_B.
  - LOAD_B: D <= in_data[W-1:0].
    - If in_data[W-1:0]==0: go to DONE and set div_zero. Quotient is forced to all ones; remainder is forced to 0.
    - Otherwise go to SUB.
  - SUB: if R >= zero-extended D, then R <= R-D, Q <= Q+1, stay in SUB. Otherwise remainder_o <= R[W-1:0] and go to DONE.
  - DONE: done_o=1 for exactly this cycle; go to IDLE unconditionally.
- Latency:
  - start_i sampled in cycle N: LOAD_A is cycle N+1, LOAD_B is N+2.
  - done_o is high in cycle N+4+q, where q is the quotient.
  - Divide by zero: done_o is high in cycle N+3.
- Comparison and subtraction are done at 2W bits with D zero-extended.
  - R never underflows, because subtraction happens only when R >= D.
  - Q cannot overflow: q max is 2^(2W)-1, reached with divisor 1.
- Result hold:
  - quotient_o, remainder_o and div_zero_o stay valid from DONE until the next LOAD_A cycle.
  - In LOAD_A, quotient_o, remainder_o and div_zero_o clear.
- Boundaries:
  - start_i is ignored in every state except IDLE. This includes the DONE cycle.
  - Dividend 0: no subtraction occurs; q=0 and r=0; done_o at N+4.
  - Dividend < divisor: q=0 and r=dividend; done_o at N+4.
  - Dividend equal to divisor: exactly one subtraction; q=1, r=0.
  - in_data is don't-care outside LOAD_A and LOAD_B.
  - busy_o is high in LOAD_A, LOAD_B, SUB and DONE.

Decomposition:
- Package div_pkg holds:
  - the state enum div_state_t {IDLE, LOAD_A, LOAD_B, SUB, DONE};
  - a default width constant DIV_W = 4.
- Sub-module div_datapath holds:
  - the R, D and Q registers;
  - the 2W-bit subtractor and >= comparator;
  - the zero-divisor detect.
- Control signals into div_datapath: load_r, load_d, clr_q, sub_en, set_dz.
- Status outputs from div_datapath: ge_o (R >= D) and dz_o (divisor is zero).
- The FSM lives in divider itself.

Test Plan:
- 12 / 4 (W=4): start at cycle N, in_data=12 then 4 -> q=3, r=0, done_o at N+7, div_zero_o=0.
- 255 / 1: dividend 8'hFF, divisor 1 -> q=255, r=0, done_o at N+259; busy_o high through N+259.
- 7 / 0: divisor 0 -> done_o at N+3; div_zero_o=1, q=8'hFF, r=0.
- 3 / 9 then 9 / 9 back-to-back:
  - first: q=0, r=3, done_o at N+4;
  - second, start one cycle after DONE: q=1, r=0;
  - a start_i pulse in the DONE cycle is ignored.
- Reset mid-operation: 200 / 3, rst_in low during SUB -> all outputs 0 immediately; after release, state is IDLE; a new 50 / 7 gives q=7, r=1.
- Randomised sweep over all 256x16 operand pairs -> q*d + r == dividend and r < d for every nonzero divisor; checked against the multiplier's product for round-trip consistency.
